psum_shift_sum: RTL and testbench

- Shift-and-sum stage directly downstream of the PE datapath controller and multiplier.
- Takes one bit-serial partial product per MAIN handshake, shifts it by the controller-supplied `sht_num`, and accumulates it into a running psum.
- Seeds the psum from zero or from the psum pad. On `psumwrite` it writes back to the psum pad; on the last row it emits the finished psum on an output rdy/ack port.
- 2-stage pipeline: S1 = shift/register, S2 = accumulate/write.

---
 rtl/psum_shift_sum.sv | 252 +++++++++++++++++++++++++
 tb/tb_psum_shift_sum.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_shift_sum.sv
// psum_shift_sum: shift-and-accumulate stage behind the PE multiplier.
// Optional macro PSUM_SS_SAT_EN selects saturating adds; without it, D16 truncates and D32 wraps.
module psum_shift_sum #(
  parameter int PRODWD     = 16,
  parameter int ACCWD      = 32,
  parameter int SHTWD      = 5,
  parameter int PPADADDRWD = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_prod_rdy,
  output logic                  o_prod_ack,
  input  logic [PRODWD-1:0]     i_prod,
  input  logic                  i_resetsum,
  input  logic                  i_psumread,
  input  logic                  i_psumwrite,
  input  logic                  i_lstrow,
  input  logic                  i_psum_mode,
  input  logic [SHTWD-1:0]      i_sht_num,
  input  logic [PPADADDRWD-1:0] i_waddr,
  input  logic [ACCWD-1:0]      i_pp_rdata,
  output logic                  o_pp_write,
  output logic [PPADADDRWD-1:0] o_pp_waddr,
  output logic [ACCWD-1:0]      o_pp_wdata,
  output logic                  o_out_rdy,
  input  logic                  i_out_ack,
  output logic [ACCWD-1:0]      o_out_data,
  output logic [7:0]            o_wr_cnt
);

  // Handshakes: a product moves on the edge where i_prod_rdy && o_prod_ack;
  // a final psum moves on the edge where o_out_rdy && i_out_ack. Neither
  // valid ever depends combinationally on its own ready.
  typedef enum logic {OIDLE = 1'b0, OFULL = 1'b1} out_state_e;

  out_state_e            out_state_q, out_state_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ACCWD-1:0]      s1_val_q, s1_val_d;
  logic                  s1_resetsum_q, s1_resetsum_d;
  logic                  s1_psumread_q, s1_psumread_d;
  logic                  s1_psumwrite_q, s1_psumwrite_d;
  logic                  s1_lstrow_q, s1_lstrow_d;
  logic                  s1_mode_q, s1_mode_d;
  logic [PPADADDRWD-1:0] s1_waddr_q, s1_waddr_d;
  logic [ACCWD-1:0]      acc_q, acc_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [PPADADDRWD-1:0] wr_addr_pend_q, wr_addr_pend_d;
  logic [ACCWD-1:0]      wr_data_pend_q, wr_data_pend_d;
  logic                  pp_write_q, pp_write_d;
  logic [PPADADDRWD-1:0] pp_waddr_q, pp_waddr_d;
  logic [ACCWD-1:0]      pp_wdata_q, pp_wdata_d;
  logic [ACCWD-1:0]      out_data_q, out_data_d;
  logic [7:0]            wr_cnt_q, wr_cnt_d;

  logic                  s1_stall;
  logic                  s1_adv;
  logic                  accept;
  logic                  out_load;
  logic [ACCWD-1:0]      prod_ext;
  logic [ACCWD-1:0]      shifted;
  logic [ACCWD-1:0]      base;
  logic [ACCWD-1:0]      sum;
  logic [ACCWD-1:0]      sum_d32;
  logic [ACCWD-1:0]      sum_d16;

  assign s1_stall   = s1_valid_q && s1_lstrow_q && s1_psumwrite_q &&
                      (out_state_q == OFULL) && !i_out_ack;
  assign o_prod_ack = !(s1_valid_q && s1_stall) && !i_clear;
  assign accept     = i_prod_rdy && o_prod_ack;
  assign s1_adv     = s1_valid_q && !s1_stall;
  assign out_load   = s1_adv && s1_psumwrite_q && s1_lstrow_q;

  // Shift amounts at or beyond the accumulator width flush the product to zero.
  always_comb begin
    prod_ext = {{(ACCWD-PRODWD){i_prod[PRODWD-1]}}, i_prod};
    shifted  = '0;
    if (int'(i_sht_num) < ACCWD) begin
      shifted = prod_ext << i_sht_num;
    end
  end

  assign base = s1_resetsum_q ? '0 : (s1_psumread_q ? i_pp_rdata : acc_q);

`ifdef PSUM_SS_SAT_EN
  logic [ACCWD:0] sum_ext;
  logic           d32_ovf;
  logic           d16_pos_ovf;
  logic           d16_neg_ovf;

  // The add is done one bit wider so both clamps see the exact signed sum.
  always_comb begin
    sum_ext     = {base[ACCWD-1], base} + {s1_val_q[ACCWD-1], s1_val_q};
    d32_ovf     = sum_ext[ACCWD] ^ sum_ext[ACCWD-1];
    d16_pos_ovf = !sum_ext[ACCWD] && (|sum_ext[ACCWD-1:15]);
    d16_neg_ovf = sum_ext[ACCWD] && !(&sum_ext[ACCWD-1:15]);
    sum_d32     = sum_ext[ACCWD-1:0];
    if (d32_ovf) begin
      sum_d32 = sum_ext[ACCWD] ? {1'b1, {(ACCWD-1){1'b0}}} : {1'b0, {(ACCWD-1){1'b1}}};
    end
    sum_d16 = {{(ACCWD-16){sum_ext[15]}}, sum_ext[15:0]};
    if (d16_pos_ovf) begin
      sum_d16 = {{(ACCWD-15){1'b0}}, {15{1'b1}}};
    end else if (d16_neg_ovf) begin
      sum_d16 = {{(ACCWD-15){1'b1}}, {15{1'b0}}};
    end
  end
`else
  logic [ACCWD-1:0] sum_w;

  always_comb begin
    sum_w   = base + s1_val_q;
    sum_d32 = sum_w;
    sum_d16 = {{(ACCWD-16){sum_w[15]}}, sum_w[15:0]};
  end
`endif

  assign sum = s1_mode_q ? sum_d16 : sum_d32;

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_val_d       = s1_val_q;
    s1_resetsum_d  = s1_resetsum_q;
    s1_psumread_d  = s1_psumread_q;
    s1_psumwrite_d = s1_psumwrite_q;
    s1_lstrow_d    = s1_lstrow_q;
    s1_mode_d      = s1_mode_q;
    s1_waddr_d     = s1_waddr_q;
    acc_d          = acc_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
      acc_d      = sum;
    end
    if (accept) begin
      s1_valid_d     = 1'b1;
      s1_val_d       = shifted;
      s1_resetsum_d  = i_resetsum;
      s1_psumread_d  = i_psumread;
      s1_psumwrite_d = i_psumwrite;
      s1_lstrow_d    = i_lstrow;
      s1_mode_d      = i_psum_mode;
      s1_waddr_d     = i_waddr;
    end
    if (i_clear) begin
      s1_valid_d = 1'b0;
      acc_d      = '0;
    end
  end

  // Pad writes sit one cycle in a pending register so they appear two cycles after acceptance.
  always_comb begin
    wr_pend_d      = s1_adv && s1_psumwrite_q && !s1_lstrow_q;
    wr_addr_pend_d = wr_addr_pend_q;
    wr_data_pend_d = wr_data_pend_q;
    if (wr_pend_d) begin
      wr_addr_pend_d = s1_waddr_q;
      wr_data_pend_d = sum;
    end
    pp_write_d = wr_pend_q;
    pp_waddr_d = pp_waddr_q;
    pp_wdata_d = pp_wdata_q;
    if (wr_pend_q) begin
      pp_waddr_d = wr_addr_pend_q;
      pp_wdata_d = wr_data_pend_q;
    end
    if (i_clear) begin
      wr_pend_d  = 1'b0;
      pp_write_d = 1'b0;
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    case (out_state_q)
      OIDLE: begin
        if (out_load) begin
          out_state_d = OFULL;
        end
      end
      OFULL: begin
        if (!out_load && i_out_ack) begin
          out_state_d = OIDLE;
        end
      end
      default: out_state_d = OIDLE;
    endcase
    if (out_load) begin
      out_data_d = sum;
    end
    if (i_clear) begin
      out_state_d = OIDLE;
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q + 8'(pp_write_d) + 8'(out_load);
    if (i_clear) begin
      wr_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_state_q    <= OIDLE;
      s1_valid_q     <= 1'b0;
      s1_val_q       <= '0;
      s1_resetsum_q  <= 1'b0;
      s1_psumread_q  <= 1'b0;
      s1_psumwrite_q <= 1'b0;
      s1_lstrow_q    <= 1'b0;
      s1_mode_q      <= 1'b0;
      s1_waddr_q     <= '0;
      acc_q          <= '0;
      wr_pend_q      <= 1'b0;
      wr_addr_pend_q <= '0;
      wr_data_pend_q <= '0;
      pp_write_q     <= 1'b0;
      pp_waddr_q     <= '0;
      pp_wdata_q     <= '0;
      out_data_q     <= '0;
      wr_cnt_q       <= '0;
    end else begin
      out_state_q    <= out_state_d;
      s1_valid_q     <= s1_valid_d;
      s1_val_q       <= s1_val_d;
      s1_resetsum_q  <= s1_resetsum_d;
      s1_psumread_q  <= s1_psumread_d;
      s1_psumwrite_q <= s1_psumwrite_d;
      s1_lstrow_q    <= s1_lstrow_d;
      s1_mode_q      <= s1_mode_d;
      s1_waddr_q     <= s1_waddr_d;
      acc_q          <= acc_d;
      wr_pend_q      <= wr_pend_d;
      wr_addr_pend_q <= wr_addr_pend_d;
      wr_data_pend_q <= wr_data_pend_d;
      pp_write_q     <= pp_write_d;
      pp_waddr_q     <= pp_waddr_d;
      pp_wdata_q     <= pp_wdata_d;
      out_data_q     <= out_data_d;
      wr_cnt_q       <= wr_cnt_d;
    end
  end

  assign o_pp_write = pp_write_q;
  assign o_pp_waddr = pp_waddr_q;
  assign o_pp_wdata = pp_wdata_q;
  assign o_out_rdy  = (out_state_q == OFULL);
  assign o_out_data = out_data_q;
  assign o_wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_psum_shift_sum.sv
// Bench for psum_shift_sum: vector table through a pad/output scoreboard plus
// hand sequences for latency, backpressure, clear and mid-stream reset.
module tb_psum_shift_sum;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clear;
  logic        i_prod_rdy;
  logic        o_prod_ack;
  logic [15:0] i_prod;
  logic        i_resetsum;
  logic        i_psumread;
  logic        i_psumwrite;
  logic        i_lstrow;
  logic        i_psum_mode;
  logic [4:0]  i_sht_num;
  logic [3:0]  i_waddr;
  logic [31:0] i_pp_rdata;
  logic        o_pp_write;
  logic [3:0]  o_pp_waddr;
  logic [31:0] o_pp_wdata;
  logic        o_out_rdy;
  logic        i_out_ack;
  logic [31:0] o_out_data;
  logic [7:0]  o_wr_cnt;

  psum_shift_sum dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_prod_rdy(i_prod_rdy), .o_prod_ack(o_prod_ack), .i_prod(i_prod),
    .i_resetsum(i_resetsum), .i_psumread(i_psumread), .i_psumwrite(i_psumwrite),
    .i_lstrow(i_lstrow), .i_psum_mode(i_psum_mode), .i_sht_num(i_sht_num),
    .i_waddr(i_waddr), .i_pp_rdata(i_pp_rdata), .o_pp_write(o_pp_write),
    .o_pp_waddr(o_pp_waddr), .o_pp_wdata(o_pp_wdata), .o_out_rdy(o_out_rdy),
    .i_out_ack(i_out_ack), .o_out_data(o_out_data), .o_wr_cnt(o_wr_cnt)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rs;
    logic        pr;
    logic        pw;
    logic        lr;
    logic        md;
    logic [4:0]  sht;
    logic [15:0] prod;
    logic [31:0] rdata;
    logic [3:0]  waddr;
    logic [31:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] pad_q[$];
  logic [31:0] out_q[$];
  logic        mon_en = 1'b0;
  vec_t        tbl[$];

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic pr, input logic pw, input logic lr,
                              input logic md, input logic [4:0] sht, input logic [15:0] prod,
                              input logic [31:0] rdata, input logic [3:0] waddr,
                              input logic [31:0] exp);
    vec_t v;
    v.rs = rs; v.pr = pr; v.pw = pw; v.lr = lr; v.md = md; v.sht = sht;
    v.prod = prod; v.rdata = rdata; v.waddr = waddr; v.exp = exp;
    return v;
  endfunction

  // driver: present one product, push its expected result, wait for acceptance
  task automatic send(input vec_t v);
    logic ok;
    i_prod_rdy  = 1'b1;
    i_resetsum  = v.rs;
    i_psumread  = v.pr;
    i_psumwrite = v.pw;
    i_lstrow    = v.lr;
    i_psum_mode = v.md;
    i_sht_num   = v.sht;
    i_prod      = v.prod;
    i_waddr     = v.waddr;
    if (v.pw && !v.lr) pad_q.push_back({v.waddr, v.exp});
    if (v.pw && v.lr) out_q.push_back(v.exp);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge i_clk);
      ok = o_prod_ack;
      @(posedge i_clk);
      #1;
    end
    i_prod_rdy = 1'b0;
    i_pp_rdata = v.rdata;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: product %h never accepted", v.prod);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // scoreboard: compare pad writes and output handshakes against the queues
  always @(negedge i_clk) begin
    if (i_rst_n && mon_en) begin
      if (o_pp_write) begin
        if (pad_q.size() == 0) begin
          check("pad_unexpected", {o_pp_waddr, o_pp_wdata}, 36'h0);
          if ({o_pp_waddr, o_pp_wdata} == 36'h0) begin
            n_err++;
            $display("FAIL pad_unexpected: got write with empty queue, expected none");
          end
        end else begin
          check("pad_write", {o_pp_waddr, o_pp_wdata}, pad_q.pop_front());
        end
      end
      if (o_out_rdy && i_out_ack) begin
        if (out_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got %h expected no output", o_out_data);
        end else begin
          check("out_data", {4'h0, o_out_data}, {4'h0, out_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic seen_wr;
    i_rst_n = 1'b0; i_clear = 1'b0; i_prod_rdy = 1'b0; i_prod = '0;
    i_resetsum = 1'b0; i_psumread = 1'b0; i_psumwrite = 1'b0; i_lstrow = 1'b0;
    i_psum_mode = 1'b0; i_sht_num = '0; i_waddr = '0; i_pp_rdata = '0; i_out_ack = 1'b1;

    // vector table: {rs, pr, pw, lr, md, sht, prod, rdata, waddr, expected}
    tbl.push_back(mk(0, 1, 1, 0, 0, 5'd3, 16'd7, 32'd100, 4'd2, 32'd156));
    tbl.push_back(mk(1, 1, 1, 0, 0, 5'd3, 16'd7, 32'd100, 4'd3, 32'd56));
    tbl.push_back(mk(1, 0, 1, 0, 0, 5'd4, 16'h8000, 32'd0, 4'd6, 32'hFFF8_0000));
    tbl.push_back(mk(1, 0, 1, 0, 0, 5'd31, 16'd1, 32'd0, 4'd7, 32'h8000_0000));
    tbl.push_back(mk(1, 0, 1, 0, 0, 5'd16, 16'h7FFF, 32'd0, 4'd8, 32'h7FFF_0000));
`ifdef PSUM_SS_SAT_EN
    tbl.push_back(mk(0, 1, 1, 0, 0, 5'd0, 16'd1, 32'h7FFF_FFFF, 4'd10, 32'h7FFF_FFFF));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5'd0, 16'hFFFF, 32'h8000_0000, 4'd11, 32'h8000_0000));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'd1, 32'd32767, 4'd12, 32'h0000_7FFF));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'hFFFF, 32'hFFFF_8000, 4'd13, 32'hFFFF_8000));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'd0, 32'h0001_0000, 4'd14, 32'h0000_7FFF));
`else
    tbl.push_back(mk(0, 1, 1, 0, 0, 5'd0, 16'd1, 32'h7FFF_FFFF, 4'd10, 32'h8000_0000));
    tbl.push_back(mk(0, 1, 1, 0, 0, 5'd0, 16'hFFFF, 32'h8000_0000, 4'd11, 32'h7FFF_FFFF));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'd1, 32'd32767, 4'd12, 32'hFFFF_8000));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'hFFFF, 32'hFFFF_8000, 4'd13, 32'h0000_7FFF));
    tbl.push_back(mk(0, 1, 1, 0, 1, 5'd0, 16'd0, 32'h0001_0000, 4'd14, 32'h0000_0000));
`endif
    tbl.push_back(mk(1, 0, 1, 0, 1, 5'd0, 16'hFFFB, 32'd0, 4'd15, 32'hFFFF_FFFB));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5'd0, 16'd10, 32'd0, 4'd0, 32'd0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5'd2, 16'd3, 32'd0, 4'd1, 32'd22));
    tbl.push_back(mk(1, 0, 1, 1, 0, 5'd1, 16'd21, 32'd0, 4'd0, 32'd42));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5'd0, 16'hFFFE, 32'd0, 4'd9, 32'd40));

    // reset values
    idle(3);
    check("rst_pp_write", {35'h0, o_pp_write}, 36'h0);
    check("rst_out_rdy", {35'h0, o_out_rdy}, 36'h0);
    check("rst_out_data", {4'h0, o_out_data}, 36'h0);
    check("rst_wr_cnt", {28'h0, o_wr_cnt}, 36'h0);
    check("rst_pp_wdata", {o_pp_waddr, o_pp_wdata}, 36'h0);
    i_rst_n = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // shift-add chain with write latency
    send(mk(1, 0, 0, 0, 0, 5'd0, 16'd3, 32'd0, 4'd0, 32'd0));
    send(mk(0, 0, 0, 0, 0, 5'd1, 16'd5, 32'd0, 4'd0, 32'd0));
    send(mk(0, 0, 1, 0, 0, 5'd2, 16'hFFFF, 32'd0, 4'd4, 32'd9));
    @(negedge i_clk); check("chain_lat0", {35'h0, o_pp_write}, 36'h0);
    @(negedge i_clk); check("chain_lat1", {35'h0, o_pp_write}, 36'h0);
    @(negedge i_clk); check("chain_lat2", {35'h0, o_pp_write}, 36'h1);
    check("chain_wr_cnt", {28'h0, o_wr_cnt}, 36'h1);
    @(negedge i_clk); check("chain_one_cycle", {35'h0, o_pp_write}, 36'h0);
    @(posedge i_clk); #1;

    foreach (tbl[i]) send(tbl[i]);
    idle(4);

    // output backpressure and no-bubble reload
    i_out_ack = 1'b0;
    send(mk(1, 0, 1, 1, 0, 5'd0, 16'd42, 32'd0, 4'd0, 32'd42));
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      if (k > 0) begin
        check("bp_rdy_held", {35'h0, o_out_rdy}, 36'h1);
        check("bp_data_held", {4'h0, o_out_data}, 36'd42);
      end
    end
    @(posedge i_clk); #1;
    send(mk(1, 0, 1, 1, 0, 5'd0, 16'd2, 32'd0, 4'd0, 32'd2));
    @(negedge i_clk);
    check("bp_ack_low", {35'h0, o_prod_ack}, 36'h0);
    check("bp_data_42", {4'h0, o_out_data}, 36'd42);
    @(posedge i_clk); #1;
    i_out_ack = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("bp_reload_rdy", {35'h0, o_out_rdy}, 36'h1);
    check("bp_reload_data", {4'h0, o_out_data}, 36'd2);
    @(posedge i_clk); #1;
    idle(3);

    // clear during a stalled full output
    i_out_ack = 1'b0;
    send(mk(1, 0, 1, 1, 0, 5'd0, 16'd7, 32'd0, 4'd0, 32'd7));
    send(mk(1, 0, 1, 1, 0, 5'd0, 16'd8, 32'd0, 4'd0, 32'd8));
    i_clear = 1'b1;
    @(negedge i_clk);
    check("clr_ack_low", {35'h0, o_prod_ack}, 36'h0);
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    out_q.delete();
    @(negedge i_clk);
    check("clr_out_rdy", {35'h0, o_out_rdy}, 36'h0);
    check("clr_wr_cnt", {28'h0, o_wr_cnt}, 36'h0);
    @(posedge i_clk); #1;
    i_out_ack = 1'b1;
    send(mk(0, 0, 1, 0, 0, 5'd0, 16'd0, 32'd0, 4'd5, 32'd0));
    send(mk(1, 0, 1, 1, 0, 5'd0, 16'd1, 32'd0, 4'd0, 32'd1));
    idle(5);

    // reset with a pad write pending
    send(mk(1, 0, 1, 0, 0, 5'd0, 16'd9, 32'd0, 4'd1, 32'd9));
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_pp_write", {35'h0, o_pp_write}, 36'h0);
    check("mid_rst_wr_cnt", {28'h0, o_wr_cnt}, 36'h0);
    check("mid_rst_pp_wdata", {4'h0, o_pp_wdata}, 36'h0);
    check("mid_rst_out_rdy", {35'h0, o_out_rdy}, 36'h0);
    pad_q.delete();
    out_q.delete();
    idle(2);
    #3 i_rst_n = 1'b1;
    seen_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_pp_write) seen_wr = 1'b1;
    end
    check("mid_rst_no_write", {35'h0, seen_wr}, 36'h0);
    @(posedge i_clk); #1;

    for (int k = 0; k < 20 && (pad_q.size() != 0 || out_q.size() != 0); k++) idle(1);
    check("drain_pad_q", 36'(pad_q.size()), 36'h0);
    check("drain_out_q", 36'(out_q.size()), 36'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
